wb_uart_rx_fifo: RTL and testbench
==================================

// Module: wb_uart_rx_fifo
// PURPOSE
//  Downstream buffer for the UART receiver. Captures each byte the receiver announces on its
//  interrupt, acknowledges it, and queues it in a DEPTH-entry FIFO. Exposes a two-register
//  Wishbone slave (data/status) to the CPU, with a level interrupt raised while the FIFO is
//  non-empty. Decouples CPU read latency from line rate, so no bytes are lost on bursts.
// PARAMETERS
//  DEPTH  16  FIFO entries; power of two, >= 2. AW = $clog2(DEPTH); occupancy count is AW+1 bits.
// PORTS
//  wb_clk_i    in   1  single clock for all logic
//  wb_rst_i    in   1  reset, asynchronous, active-high
//  wb_stb_i    in   1  Wishbone strobe (cycle implied)
//  wb_we_i     in   1  1 = write, 0 = read
//  wb_adr_i    in   1  0 = DATA, 1 = STATUS
//  wb_dat_i    in   8  write data (STATUS writes only)
//  wb_dat_o    out  8  read data, registered
//  wb_ack_o    out  1  ack, registered
//  int_o       out  1  high while FIFO non-empty
//  rx_int_i    in   1  receiver "byte ready" level (its int_uart_rx)
//  rx_dat_i    in   8  receiver byte (its wb_dat_o), valid while rx_int_i=1
//  rx_stb_o    out  1  one-cycle pulse to receiver's wb_stb_i; clears its interrupt
// BEHAVIOUR
//  Reset: async assertion clears FSM to IDLE, rd/wr pointers, count and overrun to 0;
//   wb_dat_o=0, wb_ack_o=0, rx_stb_o=0, int_o=0. FIFO storage is not reset.
//  Capture FSM (2 states):
//   IDLE: if rx_int_i=1 -> push rx_dat_i (or set overrun if no room), rx_stb_o<=1, go ACK.
//   ACK : rx_stb_o<=0, go IDLE. rx_int_i is ignored here; the receiver drops it on this edge.
//   Exactly one push attempt per receiver byte; rx_stb_o is high for exactly 1 cycle.
//  Wishbone: wb_ack_o <= wb_stb_i & ~wb_ack_o (1-cycle latency; back-to-back strobes ack
//   every other cycle). A transfer is the cycle where stb=1 and ack=0; only then do side
//   effects occur.
//   Read DATA   : wb_dat_o <= head; pop if count!=0. Empty -> wb_dat_o<=8'h00, no pop, no flag.
//   Read STATUS : wb_dat_o <= {5'b0, overrun, full, ~empty} (bits 2,1,0).
//   Write STATUS: wb_dat_i[2]=1 clears overrun. Other bits are ignored.
//   Write DATA  : ignored, still acked.
//   When no transfer occurs, wb_dat_o holds its value.
//  FIFO: pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
//   Push is accepted if ~full, or if full and a pop occurs in the same cycle.
//   Push and pop in the same cycle: both take effect, and count is unchanged.
//   Rejected push: byte dropped, overrun<=1 (sticky until cleared or reset). If a clear and a
//   set of overrun occur in the same cycle, set wins.
//  int_o = (count != 0), driven from the registered count. It falls in the cycle after the pop
//   that empties the FIFO.
//  Reset mid-operation: any in-flight ack or rx_stb_o is dropped immediately. The receiver may
//   re-present its pending byte, and it is captured once reset is released.
// STRUCTURE
//  Shared package wb_uart_pkg: ADR_DATA/ADR_STATUS constants, STATUS bit indices
//   (ST_NEMPTY=0, ST_FULL=1, ST_OVR=2), capture FSM state encoding.
//  Sub-module fifo_sync #(WIDTH, DEPTH): storage, pointers, count, full/empty, with push/pop
//   and simultaneous push+pop semantics as above. The top level holds the FSM, the Wishbone
//   decode and overrun.
// TESTING
//  1 Reset, then byte 8'hA5 from receiver model -> rx_stb_o 1 cycle later for 1 cycle;
//    int_o=1; DATA read returns A5; int_o=0.
//  2 Push 3 bytes 01,02,03 -> STATUS reads 8'h01; three DATA reads return 01,02,03 in order;
//    STATUS then reads 8'h00.
//  3 Push DEPTH+1 bytes, no reads -> STATUS reads 8'h07; first DEPTH bytes read back intact;
//    write STATUS 8'h04 -> STATUS reads 8'h00.
//  4 FIFO full; receiver byte arrives in the same cycle as a DATA read -> no overrun;
//    count stays DEPTH; new byte is read last.
//  5 DATA read when empty -> ack after 1 cycle, wb_dat_o=00, STATUS unchanged;
//    stb held 4 cycles -> ack pattern 0,1,0,1.
//  6 Assert wb_rst_i asynchronously mid-ACK with 2 bytes queued -> all outputs 0 before the
//    next edge; FIFO empty after release.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the UART receive buffer slice.
//  - Wishbone register addresses (DATA / STATUS)
//  - STATUS register bit positions
//  - Capture FSM state encoding
//  - Helper that packs the STATUS byte
package wb_uart_pkg;

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVR    = 2;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_ACK  = 1'b1
  } cap_state_t;

  function automatic logic [7:0] pack_status(input logic ovr, input logic full,
                                             input logic nempty);
    logic [7:0] s;
    s            = 8'h00;
    s[ST_OVR]    = ovr;
    s[ST_FULL]   = full;
    s[ST_NEMPTY] = nempty;
    return s;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count.
//  Ports:
//   clk, rst    clock, asynchronous active-high reset (pointers/count only)
//   push, din   write request and data
//   pop         read request; ignored while empty
//   dout        head entry (valid while ~empty)
//   full, empty occupancy flags
//   push_drop   push was rejected this cycle (full and no pop)
//  A push while full is accepted when a pop happens in the same cycle.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             push_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok, push_ok;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok    = pop & ~empty;
  assign push_ok   = push & (~full | pop_ok);
  assign push_drop = push & ~push_ok;
  assign dout      = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only observable once written,
  // and leaving them out of reset lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_uart_rx_fifo.sv
// Receive-side buffer between a UART receiver and a Wishbone CPU bus.
//  Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   wb_stb_i, wb_we_i    Wishbone strobe / write enable
//   wb_adr_i             0 = DATA, 1 = STATUS
//   wb_dat_i, wb_dat_o   write data (STATUS only) / registered read data
//   wb_ack_o             registered ack, one cycle after a strobe
//   int_o                high while the FIFO holds data
//   rx_int_i, rx_dat_i   receiver byte-ready level and its byte
//   rx_stb_o             one-cycle pulse that clears the receiver interrupt
//  STATUS = {5'b0, overrun, full, not_empty}. Writing STATUS with bit 2 set
//  clears the sticky overrun flag.
module wb_uart_rx_fifo
  import wb_uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic       wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       int_o,
  input  logic       rx_int_i,
  input  logic [7:0] rx_dat_i,
  output logic       rx_stb_o
);

  cap_state_t state, state_next;
  logic       cap_push;
  logic       xfer, rd_data, rd_status, wr_status;
  logic [7:0] fifo_head;
  logic       fifo_full, fifo_empty, push_drop;
  logic       overrun;
  logic       unused_dat;

  // Only bit 2 of a STATUS write carries meaning.
  assign unused_dat = ^{wb_dat_i[7:3], wb_dat_i[1:0]};

  // ---------------- capture FSM ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= CAP_IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default before the
  // case statement, so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    cap_push   = 1'b0;
    case (state)
      CAP_IDLE: if (rx_int_i) begin
        cap_push   = 1'b1;
        state_next = CAP_ACK;
      end
      // The receiver drops rx_int_i on the edge that leaves ACK, so it is
      // not sampled here; that guarantees one push per byte.
      CAP_ACK:  state_next = CAP_IDLE;
      default:  state_next = CAP_IDLE;
    endcase
  end

  // The strobe is exactly the one cycle spent in ACK, straight from a flop.
  assign rx_stb_o = (state == CAP_ACK);

  // ---------------- Wishbone decode ----------------
  assign xfer      = wb_stb_i & ~wb_ack_o;
  assign rd_data   = xfer & ~wb_we_i & (wb_adr_i == ADR_DATA);
  assign rd_status = xfer & ~wb_we_i & (wb_adr_i == ADR_STATUS);
  assign wr_status = xfer &  wb_we_i & (wb_adr_i == ADR_STATUS);

  fifo_sync #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (cap_push),
    .din       (rx_dat_i),
    .pop       (rd_data),
    .dout      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_drop (push_drop)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      wb_ack_o <= wb_stb_i & ~wb_ack_o;
      if (rd_data)        wb_dat_o <= fifo_empty ? 8'h00 : fifo_head;
      else if (rd_status) wb_dat_o <= pack_status(overrun, fifo_full, ~fifo_empty);
      // A dropped byte in the same cycle as a clear leaves the flag set.
      if (push_drop)                         overrun <= 1'b1;
      else if (wr_status && wb_dat_i[ST_OVR]) overrun <= 1'b0;
    end
  end

  // Derived from the registered count, so it falls right after the last pop.
  assign int_o = ~fifo_empty;

endmodule

// File: tb/tb_wb_uart_rx_fifo.sv
// Self-checking bench for wb_uart_rx_fifo: directed scenarios followed by a
// randomized phase, all compared against a queue-based model of the buffer.
module tb_wb_uart_rx_fifo;
  import wb_uart_pkg::*;

  localparam int DEPTH = 16;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i, wb_stb_i, wb_we_i, wb_adr_i;
  logic [7:0] wb_dat_i, wb_dat_o, rx_dat_i;
  logic       wb_ack_o, int_o, rx_int_i, rx_stb_o;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .int_o    (int_o),
    .rx_int_i (rx_int_i),
    .rx_dat_i (rx_dat_i),
    .rx_stb_o (rx_stb_o)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: byte queue plus sticky overrun flag.
  logic [7:0] q[$];
  bit         m_ovr;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    int v;
    v = (m_ovr ? 4 : 0) + ((q.size() == DEPTH) ? 2 : 0) + ((q.size() != 0) ? 1 : 0);
    return 8'(v);
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else                  m_ovr = 1'b1;
  endfunction

  function automatic logic [7:0] m_pop();
    if (q.size() == 0) return 8'h00;
    return q.pop_front();
  endfunction

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Receiver model: hold the byte until the strobe, drop it on the next edge.
  task automatic send_byte(input logic [7:0] b);
    rx_int_i = 1'b1;
    rx_dat_i = b;
    tick();
    check("rx_stb_pulse", 8'(rx_stb_o), 8'd1);
    m_push(b);
    tick();
    check("rx_stb_end", 8'(rx_stb_o), 8'd0);
    rx_int_i = 1'b0;
  endtask

  task automatic wb_access(input logic we, input logic adr, input logic [7:0] d,
                           output logic [7:0] obs);
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = d;
    tick();
    check("ack_rise", 8'(wb_ack_o), 8'd1);
    obs      = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    tick();
    check("ack_fall", 8'(wb_ack_o), 8'd0);
  endtask

  task automatic read_data(input string tag, output logic [7:0] obs);
    logic [7:0] exp;
    exp = m_pop();
    wb_access(1'b0, ADR_DATA, 8'h00, obs);
    check(tag, obs, exp);
  endtask

  task automatic read_status(input string tag);
    logic [7:0] obs, exp;
    exp = m_status();
    wb_access(1'b0, ADR_STATUS, 8'h00, obs);
    check(tag, obs, exp);
  endtask

  task automatic write_reg(input logic adr, input logic [7:0] d);
    logic [7:0] obs;
    if (adr == ADR_STATUS && d[2]) m_ovr = 1'b0;
    wb_access(1'b1, adr, d, obs);
  endtask

  task automatic check_int(input string tag);
    check(tag, 8'(int_o), (q.size() != 0) ? 8'd1 : 8'd0);
  endtask

  initial begin
    logic [7:0] obs, b, last;

    // ---------- reset ----------
    wb_rst_i = 1'b1; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 1'b0;
    wb_dat_i = 8'h00; rx_int_i = 1'b0; rx_dat_i = 8'h00;
    m_ovr = 1'b0;
    tick();
    check("rst_ack", 8'(wb_ack_o), 8'd0);
    check("rst_dat", wb_dat_o, 8'h00);
    check("rst_int", 8'(int_o), 8'd0);
    check("rst_rxstb", 8'(rx_stb_o), 8'd0);
    wb_rst_i = 1'b0;
    tick();

    // ---------- 1: single byte ----------
    send_byte(8'hA5);
    check_int("t1_int_hi");
    read_data("t1_data", obs);
    check("t1_a5", obs, 8'hA5);
    check_int("t1_int_lo");

    // ---------- 2: three bytes in order ----------
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    read_status("t2_status_ne");
    for (int i = 0; i < 3; i++) read_data("t2_data", obs);
    read_status("t2_status_empty");

    // ---------- 3: overflow by one ----------
    for (int i = 0; i <= DEPTH; i++) send_byte(8'($urandom));
    read_status("t3_status_full_ovr");
    for (int i = 0; i < DEPTH; i++) read_data("t3_data", obs);
    read_status("t3_status_ovr_only");
    last = wb_dat_o;
    write_reg(ADR_STATUS, 8'h04);
    check("t3_dat_hold", wb_dat_o, last);
    read_status("t3_status_cleared");

    // ---------- 4: push into full FIFO with simultaneous pop ----------
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom));
    read_status("t4_status_full");
    b = 8'($urandom);
    rx_int_i = 1'b1; rx_dat_i = b;
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = ADR_DATA;
    tick();
    check("t4_ack", 8'(wb_ack_o), 8'd1);
    check("t4_head", wb_dat_o, m_pop());
    check("t4_rx_stb", 8'(rx_stb_o), 8'd1);
    m_push(b);
    wb_stb_i = 1'b0;
    tick();
    rx_int_i = 1'b0;
    check("t4_rx_stb_end", 8'(rx_stb_o), 8'd0);
    read_status("t4_status_no_ovr");
    for (int i = 0; i < DEPTH; i++) read_data("t4_data", last);
    check("t4_new_last", last, b);

    // ---------- 5: empty read and back-to-back strobes ----------
    read_status("t5_status_before");
    read_data("t5_empty_data", obs);
    check("t5_empty_zero", obs, 8'h00);
    read_status("t5_status_after");
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = ADR_DATA;
    check("t5_ack0", 8'(wb_ack_o), 8'd0);
    tick(); check("t5_ack1", 8'(wb_ack_o), 8'd1);
    tick(); check("t5_ack2", 8'(wb_ack_o), 8'd0);
    tick(); check("t5_ack3", 8'(wb_ack_o), 8'd1);
    tick();
    wb_stb_i = 1'b0;
    check("t5_dat_zero", wb_dat_o, 8'h00);
    tick();

    // ---------- 6: async reset mid-ACK ----------
    send_byte(8'h11); send_byte(8'h22);
    b = 8'h5C;
    rx_int_i = 1'b1; rx_dat_i = b;
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = ADR_STATUS;
    tick();
    check("t6_in_ack", 8'(rx_stb_o), 8'd1);
    check("t6_wb_ack", 8'(wb_ack_o), 8'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    check("t6_rst_rxstb", 8'(rx_stb_o), 8'd0);
    check("t6_rst_ack", 8'(wb_ack_o), 8'd0);
    check("t6_rst_dat", wb_dat_o, 8'h00);
    check("t6_rst_int", 8'(int_o), 8'd0);
    wb_stb_i = 1'b0;
    q.delete();
    m_ovr = 1'b0;
    tick();
    check("t6_hold_rxstb", 8'(rx_stb_o), 8'd0);
    wb_rst_i = 1'b0;
    check_int("t6_empty_after");
    send_byte(b);
    read_status("t6_status_one");
    read_data("t6_recapture", obs);
    read_status("t6_status_empty");

    // ---------- randomized traffic ----------
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    send_byte(8'($urandom));
        2:       read_data("rnd_data", obs);
        3:       read_status("rnd_status");
        4:       write_reg(ADR_STATUS, 8'($urandom));
        default: write_reg(ADR_DATA, 8'($urandom));
      endcase
      check_int("rnd_int");
    end
    read_status("rnd_final_status");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
